// File: rtl/dh_modexp_if.sv
// Start/done handshake bundle for dh_modexp.
// The master drives the operands; the slave returns busy/done/r/err.
interface dh_modexp_if #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 32
);
    logic             start;
    logic [WIDTH-1:0] g;
    logic [EXP_W-1:0] x;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             err;

    modport master (output start, g, x, p, input busy, done, r, err);
    modport slave  (input start, g, x, p, output busy, done, r, err);
endinterface

// File: rtl/dh_modexp.sv
// dh_modexp: r = g^x mod p using left-to-right square-and-multiply on a bit-serial modular multiplier.
// Optional macro DH_SKIP_ZERO_MUL_EN skips the multiply pass for zero exponent bits (not constant-time).
module dh_modexp #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 32
) (
    input logic        clk,
    input logic        rst,
    dh_modexp_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int IW = $clog2(EXP_W);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [IW-1:0]    IDX_TOP  = IW'(EXP_W - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    typedef enum logic [2:0] {IDLE, PRE, SQR, MUL, FIN} state_t;

    state_t           state;
    logic [EXP_W-1:0] xr;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] gm;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [WIDTH-1:0] mm;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH+1:0] pext;
    logic [WIDTH+1:0] dbl;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] mul_res;

    // One interleaved step: mm stays below p, so each reduction needs only one subtract.
    always_comb begin
        pext = {2'b00, pr};
        dbl  = {1'b0, mm, 1'b0};
        if (dbl >= pext) dbl = dbl - pext;
        sum = dbl + (ma[WIDTH-1] ? {2'b00, mb} : '0);
        if (sum >= pext) sum = sum - pext;
        step = WIDTH'(sum);
    end

    assign mul_res = xr[idx] ? step : acc;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r    = r_q;
    assign bus.err  = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            xr     <= '0;
            pr     <= '0;
            gm     <= '0;
            acc    <= '0;
            ma     <= '0;
            mb     <= '0;
            mm     <= '0;
            r_q    <= ONE;
            cnt    <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        xr     <= bus.x;
                        pr     <= bus.p;
                        ma     <= bus.g;
                        mb     <= ONE;
                        mm     <= '0;
                        cnt    <= '0;
                        idx    <= IDX_TOP;
                        if (bus.p < TWO) begin
                            r_q   <= '0;
                            err_q <= 1'b1;
                            state <= FIN;
                        end else begin
                            err_q <= 1'b0;
                            state <= PRE;
                        end
                    end
                end
                PRE: begin
                    cnt <= cnt + 1'b1;
                    ma  <= ma << 1;
                    mm  <= step;
                    if (cnt == CNT_LAST) begin
                        gm    <= step;
                        acc   <= ONE;
                        cnt   <= '0;
                        ma    <= ONE;
                        mb    <= ONE;
                        mm    <= '0;
                        state <= SQR;
                    end
                end
                SQR: begin
                    cnt <= cnt + 1'b1;
                    ma  <= ma << 1;
                    mm  <= step;
                    if (cnt == CNT_LAST) begin
                        acc <= step;
                        cnt <= '0;
                        mm  <= '0;
`ifdef DH_SKIP_ZERO_MUL_EN
                        if (!xr[idx]) begin
                            if (idx == '0) begin
                                state <= FIN;
                            end else begin
                                idx   <= idx - 1'b1;
                                ma    <= step;
                                mb    <= step;
                                state <= SQR;
                            end
                        end else begin
                            ma    <= step;
                            mb    <= gm;
                            state <= MUL;
                        end
`else
                        ma    <= step;
                        mb    <= gm;
                        state <= MUL;
`endif
                    end
                end
                MUL: begin
                    cnt <= cnt + 1'b1;
                    ma  <= ma << 1;
                    mm  <= step;
                    // The product is always computed; a zero exponent bit just discards it.
                    if (cnt == CNT_LAST) begin
                        acc <= mul_res;
                        cnt <= '0;
                        mm  <= '0;
                        if (idx == '0) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx - 1'b1;
                            ma    <= mul_res;
                            mb    <= mul_res;
                            state <= SQR;
                        end
                    end
                end
                FIN: begin
                    if (!err_q) r_q <= acc;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
